// File: rtl/util_tx_timestamp_gate_if.sv
// Stream bundle between the TX DMA, the timestamp gate and the sample unpacker.
// slave is the gate's view; master is the view of whoever drives the input and sinks the output.
interface util_tx_timestamp_gate_if #(
  parameter int DW = 64
);
  logic          s_axis_valid;
  logic          s_axis_ready;
  logic          s_axis_xfer_req;
  logic [DW-1:0] s_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic [DW-1:0] m_axis_data;

  modport slave (
    input  s_axis_valid, s_axis_xfer_req, s_axis_data, m_axis_ready,
    output s_axis_ready, m_axis_valid, m_axis_data
  );

  modport master (
    output s_axis_valid, s_axis_xfer_req, s_axis_data, m_axis_ready,
    input  s_axis_ready, m_axis_valid, m_axis_data
  );
endinterface

// File: rtl/util_tx_timestamp_gate.sv
// DAC-domain gate that holds each timestamped TX block until the sample clock reaches its header,
// then streams it to the unpacker with zero latency; late or far-future blocks are dropped or sent.
module util_tx_timestamp_gate #(
  parameter int NUM_OF_CHANNELS   = 4,
  parameter int SAMPLE_DATA_WIDTH = 16,
  parameter int TIMESTAMP_WIDTH   = 64,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic [31:0]                timestamp_every,
  input  logic                       late_mode,
  input  logic [TIMESTAMP_WIDTH-1:0] max_wait,
  util_tx_timestamp_gate_if.slave    axis,
  output logic [COUNT_WIDTH-1:0]     late_count,
  output logic [COUNT_WIDTH-1:0]     drop_count,
  output logic                       underflow
);

  localparam logic [TIMESTAMP_WIDTH-1:0] TS_ONE  = TIMESTAMP_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]     CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]     CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    PASS,
    HEADER,
    WAIT,
    STREAM,
    DROP
  } state_t;

  state_t                     r_state;
  state_t                     w_stateNext;
  logic                       r_xferReqD;
  logic [31:0]                r_everyL;
  logic [31:0]                r_beatCnt;
  logic [TIMESTAMP_WIDTH-1:0] r_hdr;
  logic [COUNT_WIDTH-1:0]     r_lateCount;
  logic [COUNT_WIDTH-1:0]     r_dropCount;
  logic                       r_underflow;

  logic                       w_xferRise;
  logic [TIMESTAMP_WIDTH-1:0] w_hdrIn;
  logic [TIMESTAMP_WIDTH-1:0] w_diff;
  logic                       w_isLate;
  logic                       w_tooEarly;
  logic                       w_lastBeat;
  logic                       w_sReady;
  logic                       w_mValid;
  logic                       w_hdrLoad;
  logic                       w_lateInc;
  logic                       w_dropInc;
  logic                       w_cntInc;
  logic                       w_cntClr;

  // Modular difference: its MSB is the sign, so a header just across the wrap still reads as near.
  assign w_xferRise = axis.s_axis_xfer_req & ~r_xferReqD;
  assign w_hdrIn    = axis.s_axis_data[TIMESTAMP_WIDTH-1:0];
  assign w_diff     = w_hdrIn - timestamp;
  assign w_isLate   = w_diff[TIMESTAMP_WIDTH-1];
  assign w_tooEarly = ~w_isLate & (w_diff > max_wait);
  assign w_lastBeat = (r_beatCnt == (r_everyL - 32'd1));

  assign axis.s_axis_ready = w_sReady;
  assign axis.m_axis_valid = w_mValid;
  assign axis.m_axis_data  = axis.s_axis_data;
  assign late_count        = r_lateCount;
  assign drop_count        = r_dropCount;
  assign underflow         = r_underflow;

  always_comb begin
    w_stateNext = r_state;
    w_sReady    = 1'b0;
    w_mValid    = 1'b0;
    w_hdrLoad   = 1'b0;
    w_lateInc   = 1'b0;
    w_dropInc   = 1'b0;
    w_cntInc    = 1'b0;
    w_cntClr    = 1'b0;
    case (r_state)
      IDLE: begin
        // every_l is being latched on this same edge, so decide from the live input.
        if (w_xferRise) begin
          w_stateNext = (timestamp_every != 32'd0) ? HEADER : PASS;
        end
      end
      PASS: begin
        w_mValid = axis.s_axis_valid;
        w_sReady = axis.m_axis_ready;
      end
      HEADER: begin
        w_sReady = 1'b1;
        if (axis.s_axis_valid) begin
          w_hdrLoad = 1'b1;
          if (w_isLate) begin
            w_lateInc = 1'b1;
            if (late_mode) begin
              w_stateNext = STREAM;
            end else begin
              w_dropInc   = 1'b1;
              w_stateNext = DROP;
            end
          end else if (w_tooEarly) begin
            w_dropInc   = 1'b1;
            w_stateNext = DROP;
          // A header one tick ahead is already due next cycle; WAIT would miss its hdr-1 match.
          end else if (w_diff <= TS_ONE) begin
            w_stateNext = STREAM;
          end else begin
            w_stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (timestamp == (r_hdr - TS_ONE)) begin
          w_stateNext = STREAM;
        end
      end
      STREAM: begin
        w_mValid = axis.s_axis_valid;
        w_sReady = axis.m_axis_ready;
        if (axis.s_axis_valid && axis.m_axis_ready) begin
          if (w_lastBeat) begin
            w_cntClr    = 1'b1;
            w_stateNext = HEADER;
          end else begin
            w_cntInc = 1'b1;
          end
        end
      end
      DROP: begin
        w_sReady = 1'b1;
        if (axis.s_axis_valid) begin
          if (w_lastBeat) begin
            w_cntClr    = 1'b1;
            w_stateNext = HEADER;
          end else begin
            w_cntInc = 1'b1;
          end
        end
      end
      default: w_stateNext = IDLE;
    endcase
    // Losing the transfer abandons any partial block; status counters keep their history.
    if (!axis.s_axis_xfer_req) begin
      w_stateNext = IDLE;
      w_cntClr    = 1'b1;
      w_cntInc    = 1'b0;
      w_lateInc   = 1'b0;
      w_dropInc   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_xferReqD  <= 1'b0;
      r_everyL    <= 32'd0;
      r_beatCnt   <= 32'd0;
      r_hdr       <= '0;
      r_lateCount <= '0;
      r_dropCount <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_xferReqD  <= axis.s_axis_xfer_req;
      r_underflow <= (r_state == STREAM) & ~axis.s_axis_valid & axis.m_axis_ready;
      if (w_xferRise) begin
        r_everyL <= timestamp_every;
      end
      if (w_hdrLoad) begin
        r_hdr <= w_hdrIn;
      end
      if (w_cntClr) begin
        r_beatCnt <= 32'd0;
      end else if (w_cntInc) begin
        r_beatCnt <= r_beatCnt + 32'd1;
      end
      if (w_lateInc && (r_lateCount != CNT_MAX)) begin
        r_lateCount <= r_lateCount + CNT_ONE;
      end
      if (w_dropInc && (r_dropCount != CNT_MAX)) begin
        r_dropCount <= r_dropCount + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_util_tx_timestamp_gate.sv
// Directed bench for util_tx_timestamp_gate: source and expected-output queues act as scoreboard,
// the bench owns the free-running timestamp so block release times can be predicted exactly.
module tb_util_tx_timestamp_gate;

  localparam int NCH = 4;
  localparam int SDW = 16;
  localparam int TW  = 64;
  localparam int CW  = 16;
  localparam int DW  = NCH * SDW;

  logic          clk = 1'b0;
  logic          resetn;
  logic [TW-1:0] timestamp;
  logic [31:0]   timestamp_every;
  logic          late_mode;
  logic [TW-1:0] max_wait;
  logic [CW-1:0] late_count;
  logic [CW-1:0] drop_count;
  logic          underflow;

  util_tx_timestamp_gate_if #(.DW(DW)) axis ();

  util_tx_timestamp_gate #(
    .NUM_OF_CHANNELS  (NCH),
    .SAMPLE_DATA_WIDTH(SDW),
    .TIMESTAMP_WIDTH  (TW),
    .COUNT_WIDTH      (CW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .timestamp      (timestamp),
    .timestamp_every(timestamp_every),
    .late_mode      (late_mode),
    .max_wait       (max_wait),
    .axis           (axis),
    .late_count     (late_count),
    .drop_count     (drop_count),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] srcQ[$];
  logic [DW-1:0] expQ[$];
  int            checkCnt = 0;
  int            passCnt  = 0;
  int            blkId    = 0;
  int            blockOut = 0;
  bit            readyRandom = 1'b0;
  logic [TW-1:0] firstOutTs;
  logic [TW-1:0] lastOutTs;
  logic [TW-1:0] hdr;
  int            n;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus();
    axis.m_axis_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    if (srcQ.size() != 0) begin
      axis.s_axis_valid = 1'b1;
      axis.s_axis_data  = srcQ[0];
    end else begin
      axis.s_axis_valid = 1'b0;
      axis.s_axis_data  = '0;
    end
  endtask

  task automatic checkOutput();
    logic [DW-1:0] expData;
    if (axis.m_axis_valid && axis.m_axis_ready) begin
      check("out_pending", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        expData = expQ.pop_front();
        check("out_data", axis.m_axis_data, expData);
      end
      if (blockOut == 0) firstOutTs = timestamp;
      lastOutTs = timestamp;
      blockOut++;
    end
    if (axis.s_axis_valid && axis.s_axis_ready) void'(srcQ.pop_front());
  endtask

  task automatic runCycle();
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    timestamp = timestamp + 64'd1;
  endtask

  task automatic drain(input int maxCycles, input string tag, output int cycles);
    cycles = 0;
    while ((srcQ.size() != 0 || expQ.size() != 0) && cycles < maxCycles) begin
      runCycle();
      cycles++;
    end
    check(tag, 64'(srcQ.size() + expQ.size()), 64'd0);
  endtask

  task automatic pushHeader(input logic signed [TW-1:0] offset, output logic [TW-1:0] h);
    h = timestamp + offset;
    srcQ.push_back(DW'(h));
    blockOut = 0;
    blkId++;
  endtask

  task automatic pushBeats(input int count, input bit expectOut);
    logic [DW-1:0] beat;
    for (int j = 0; j < count; j++) begin
      beat = 64'hB000_0000_0000_0000 | (64'(blkId) << 8) | 64'(j);
      srcQ.push_back(beat);
      if (expectOut) expQ.push_back(beat);
    end
  endtask

  initial begin
    resetn               = 1'b0;
    timestamp            = 64'd1000;
    timestamp_every      = 32'd0;
    late_mode            = 1'b0;
    max_wait             = 64'd1000;
    axis.s_axis_valid    = 1'b0;
    axis.s_axis_xfer_req = 1'b0;
    axis.s_axis_data     = '0;
    axis.m_axis_ready    = 1'b1;
    #12;
    check("rst_s_ready", 64'(axis.s_axis_ready), 64'd0);
    check("rst_m_valid", 64'(axis.m_axis_valid), 64'd0);
    check("rst_late", 64'(late_count), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    resetn = 1'b1;
    runCycle();
    runCycle();

    $display("[TB] pass-through, timestamp_every = 0");
    axis.s_axis_xfer_req = 1'b1;
    runCycle();
    for (int k = 0; k < 12; k++) begin
      srcQ.push_back({16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)});
      expQ.push_back({16'(4*k+4), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1)});
    end
    drain(50, "pass_drain", n);
    check("pass_cycles", 64'(n), 64'd12);
    check("pass_late", 64'(late_count), 64'd0);
    check("pass_drop", 64'(drop_count), 64'd0);
    axis.s_axis_xfer_req = 1'b0;
    runCycle();
    runCycle();

    $display("[TB] timestamped transfer, every = 4");
    timestamp_every      = 32'd4;
    axis.s_axis_xfer_req = 1'b1;
    runCycle();
    pushHeader(64'sd5, hdr);
    pushBeats(4, 1'b1);
    drain(40, "wait5_drain", n);
    check("wait5_first_ts", firstOutTs, hdr);
    check("wait5_last_ts", lastOutTs, hdr + 64'd3);

    $display("[TB] late header, drop policy");
    pushHeader(-64'sd2, hdr);
    pushBeats(4, 1'b0);
    drain(40, "late_drop_drain", n);
    check("late_drop_late", 64'(late_count), 64'd1);
    check("late_drop_drop", 64'(drop_count), 64'd1);

    $display("[TB] on-time block under random backpressure");
    readyRandom = 1'b1;
    pushHeader(64'sd3, hdr);
    pushBeats(4, 1'b1);
    drain(200, "bp_drain", n);
    readyRandom = 1'b0;
    check("bp_not_early", 64'(firstOutTs >= hdr), 64'd1);

    $display("[TB] late header, send policy");
    late_mode = 1'b1;
    pushHeader(-64'sd2, hdr);
    runCycle();
    runCycle();
    check("underflow_pulse", 64'(underflow), 64'd1);
    pushBeats(4, 1'b1);
    drain(40, "late_send_drain", n);
    check("late_send_late", 64'(late_count), 64'd2);
    check("late_send_drop", 64'(drop_count), 64'd1);
    late_mode = 1'b0;

    $display("[TB] max_wait bound, every change mid-transfer ignored");
    max_wait        = 64'd100;
    timestamp_every = 32'd9;
    pushHeader(64'sd200, hdr);
    pushBeats(4, 1'b0);
    drain(40, "early_drop_drain", n);
    check("early_drop_drop", 64'(drop_count), 64'd2);
    check("early_drop_late", 64'(late_count), 64'd2);
    pushHeader(64'sd20, hdr);
    pushBeats(4, 1'b1);
    drain(60, "wait20_drain", n);
    check("wait20_first_ts", firstOutTs, hdr);

    $display("[TB] header across timestamp wrap");
    timestamp = 64'hFFFF_FFFF_FFFF_FFFD;
    pushHeader(64'sd5, hdr);
    pushBeats(4, 1'b1);
    drain(40, "wrap_drain", n);
    check("wrap_first_ts", firstOutTs, 64'd2);

    $display("[TB] xfer_req drop mid-block, then restart");
    pushHeader(64'sd3, hdr);
    pushBeats(2, 1'b1);
    drain(40, "partial_drain", n);
    axis.s_axis_xfer_req = 1'b0;
    runCycle();
    check("idle_s_ready", 64'(axis.s_axis_ready), 64'd0);
    timestamp_every      = 32'd4;
    axis.s_axis_xfer_req = 1'b1;
    runCycle();
    pushHeader(64'sd4, hdr);
    pushBeats(4, 1'b1);
    drain(40, "restart_drain", n);
    check("restart_first_ts", firstOutTs, hdr);

    $display("[TB] reset during WAIT");
    pushHeader(64'sd50, hdr);
    pushBeats(4, 1'b0);
    runCycle();
    runCycle();
    runCycle();
    check("pre_reset_late", 64'(late_count), 64'd2);
    resetn = 1'b0;
    #1;
    check("async_rst_s_ready", 64'(axis.s_axis_ready), 64'd0);
    check("async_rst_m_valid", 64'(axis.m_axis_valid), 64'd0);
    check("async_rst_late", 64'(late_count), 64'd0);
    check("async_rst_drop", 64'(drop_count), 64'd0);
    check("async_rst_underflow", 64'(underflow), 64'd0);
    srcQ.delete();
    expQ.delete();

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
